// File: rtl/gray_conv_arbiter_if.sv
// Bus between the requesters/consumer and the shared binary-to-Gray
// converter.
//   req      : per-requester request level
//   b        : concatenated binary words, requester i at b[i*W +: W]
//   gnt      : one-hot grant pulse
//   g        : Gray result
//   g_id     : index of the requester whose word is in g
//   g_valid  : result register holds an unconsumed word
//   g_ready  : consumer accepts the result
//   conv_cnt : count of completed transfers, modulo 2^16
// The slave modport is the converter; master is the requester/consumer side.
interface gray_conv_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N*W-1:0] b;
  logic [N-1:0]   gnt;
  logic [W-1:0]   g;
  logic [IW-1:0]  g_id;
  logic           g_valid;
  logic           g_ready;
  logic [15:0]    conv_cnt;

  modport master (
    output req, b, g_ready,
    input  gnt, g, g_id, g_valid, conv_cnt
  );

  modport slave (
    input  req, b, g_ready,
    output gnt, g, g_id, g_valid, conv_cnt
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbitrated, registered binary-to-Gray converter shared by N
// requesters. The winning word is converted and held in a one-entry output
// register with a valid/ready handshake; the winner receives a one-cycle
// registered grant on the capturing edge.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : gray_conv_arbiter_if.slave (req, b, g_ready in;
//         gnt, g, g_id, g_valid, conv_cnt out)
module gray_conv_arbiter #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_conv_arbiter_if.slave    bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  win;
  logic [IW-1:0]  hi_win, lo_win;
  logic           hi_hit, lo_hit;
  logic           any_req;
  logic [W-1:0]   b_win;
  logic           capture, transfer;

  logic [N-1:0]   gnt_p1;
  logic [W-1:0]   g_p1;
  logic [IW-1:0]  g_id_p1;
  logic [15:0]    cnt_p1;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Round-robin search: the lowest set request at or above the pointer wins;
  // if none, wrap around to the lowest set request overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && (i >= int'(ptr_q)) && !hi_hit) begin
        hi_hit = 1'b1;
        hi_win = IW'(i);
      end
      if (bus.req[i] && !lo_hit) begin
        lo_hit = 1'b1;
        lo_win = IW'(i);
      end
    end
    any_req = lo_hit;
    win     = hi_hit ? hi_win : lo_win;
  end

  always_comb begin
    b_win = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == win) b_win = bus.b[i*W +: W];
    end
  end

  // A capture is possible whenever the output slot is empty or is being
  // drained in this same cycle.
  assign capture  = any_req && ((state_q == EMPTY) || bus.g_ready);
  assign transfer = (state_q == FULL) && bus.g_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (any_req) state_d = FULL;
      FULL:    if (bus.g_ready && !any_req) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p1  <= '0;
      g_p1    <= '0;
      g_id_p1 <= '0;
      cnt_p1  <= '0;
      ptr_q   <= '0;
    end else begin
      gnt_p1 <= capture ? (N'(1) << win) : '0;
      if (capture) begin
        g_p1    <= to_gray(b_win);
        g_id_p1 <= win;
        ptr_q   <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
      end
      if (transfer) cnt_p1 <= cnt_p1 + 16'd1;
    end
  end

  assign bus.gnt      = gnt_p1;
  assign bus.g        = g_p1;
  assign bus.g_id     = g_id_p1;
  assign bus.g_valid  = (state_q == FULL);
  assign bus.conv_cnt = cnt_p1;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.N(N), .W(W), .IW(IW)) bus ();

  gray_conv_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string          name;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] b;
    logic           rdy;
    logic [N-1:0]   gnt;
    logic [W-1:0]   g;
    logic [IW-1:0]  id;
    logic           vld;
    logic [15:0]    cnt;
  } vec_t;

  vec_t tv[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic add(input string nm, input logic r, input logic [N-1:0] rq,
                     input logic [N*W-1:0] bb, input logic rd,
                     input logic [N-1:0] eg, input logic [W-1:0] egr,
                     input logic [IW-1:0] eid, input logic ev,
                     input logic [15:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.b = bb; v.rdy = rd;
    v.gnt = eg; v.g = egr; v.id = eid; v.vld = ev; v.cnt = ec;
    tv.push_back(v);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic apply(input vec_t v);
    rst         = v.rst;
    bus.req     = v.req;
    bus.b       = v.b;
    bus.g_ready = v.rdy;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.gnt === v.gnt && bus.g === v.g && bus.g_id === v.id &&
        bus.g_valid === v.vld && bus.conv_cnt === v.cnt) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got gnt=%b g=%b id=%0d vld=%b cnt=%h, want gnt=%b g=%b id=%0d vld=%b cnt=%h",
               v.name, bus.gnt, bus.g, bus.g_id, bus.g_valid, bus.conv_cnt,
               v.gnt, v.g, v.id, v.vld, v.cnt);
    end
  endtask

  localparam logic [15:0] B_RR = 16'hFA70;  // b3..b0 = 1111,1010,0111,0000

  initial begin
    vec_t v;
    logic [3:0] bv;

    rst = 1'b1; bus.req = '0; bus.b = '0; bus.g_ready = 1'b0;

    //   name        rst  req      b        rdy   gnt      g        id vld cnt
    add("reset0",    1, 4'b0000, 16'h0,   1'b0, 4'b0000, 4'b0000, 0, 0, 0);
    add("reset1",    1, 4'b1111, 16'hFFFF,1'b1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add("idle",    0, 4'b0000, 16'h0,   1'b1, 4'b0000, 4'b0000, 0, 0, 0);
    add("single",    0, 4'b0001, 16'h0005,1'b1, 4'b0001, 4'b0111, 0, 1, 0);
    add("single_tx", 0, 4'b0000, 16'h0005,1'b1, 4'b0000, 4'b0111, 0, 0, 1);
    add("rr_reset",  1, 4'b0000, 16'h0,   1'b1, 4'b0000, 4'b0000, 0, 0, 0);
    add("rr0",       0, 4'b1111, B_RR,    1'b1, 4'b0001, 4'b0000, 0, 1, 0);
    add("rr1",       0, 4'b1111, B_RR,    1'b1, 4'b0010, 4'b0100, 1, 1, 1);
    add("rr2",       0, 4'b1111, B_RR,    1'b1, 4'b0100, 4'b1111, 2, 1, 2);
    add("rr3",       0, 4'b1111, B_RR,    1'b1, 4'b1000, 4'b1000, 3, 1, 3);
    add("rr4",       0, 4'b1111, B_RR,    1'b1, 4'b0001, 4'b0000, 0, 1, 4);
    add("bp_load",   0, 4'b1000, B_RR,    1'b1, 4'b1000, 4'b1000, 3, 1, 5);
    for (int i = 0; i < 3; i++)
      add("bp_hold", 0, 4'b0110, B_RR,    1'b0, 4'b0000, 4'b1000, 3, 1, 5);
    add("bp_rel1",   0, 4'b0110, B_RR,    1'b1, 4'b0010, 4'b0100, 1, 1, 6);
    add("bp_rel2",   0, 4'b0110, B_RR,    1'b1, 4'b0100, 4'b1111, 2, 1, 7);
    add("pend",      0, 4'b0000, B_RR,    1'b0, 4'b0000, 4'b1111, 2, 1, 7);
    add("mid_rst",   1, 4'b1010, B_RR,    1'b0, 4'b0000, 4'b0000, 0, 0, 0);
    add("post_rst",  0, 4'b1010, B_RR,    1'b0, 4'b0010, 4'b0100, 1, 1, 0);
    add("post_hold", 0, 4'b1010, B_RR,    1'b0, 4'b0000, 4'b0100, 1, 1, 0);
    add("post_next", 0, 4'b1010, B_RR,    1'b1, 4'b1000, 4'b1000, 3, 1, 1);
    add("post_drain",0, 4'b0000, B_RR,    1'b1, 4'b0000, 4'b1000, 3, 0, 2);
    add("withdraw",  0, 4'b0000, B_RR,    1'b0, 4'b0000, 4'b1000, 3, 0, 2);

    foreach (tv[i]) apply(tv[i]);

    // Exhaustive W=4 sweep through requester 2, back-to-back.
    v.name = "wrap_reset"; v.rst = 1; v.req = '0; v.b = '0; v.rdy = 1;
    v.gnt = '0; v.g = '0; v.id = '0; v.vld = 0; v.cnt = '0;
    apply(v);
    for (int k = 0; k < 16; k++) begin
      bv = 4'(k);
      v.name = $sformatf("gray_b%0d", k);
      v.rst = 0; v.req = 4'b0100; v.b = {4'h0, bv, 8'h00}; v.rdy = 1;
      v.gnt = 4'b0100; v.g = bv ^ (bv >> 1); v.id = 2; v.vld = 1;
      v.cnt = 16'(k);
      apply(v);
    end

    // Keep streaming until the counter reaches 0xFFFF, then wrap it.
    for (int k = 0; k < 65519; k++) @(posedge clk);
    #1;
    v.name = "cnt_ffff"; v.g = 4'b1000; v.cnt = 16'hFFFF;
    apply(v);
    v.name = "cnt_wrap"; v.cnt = 16'h0000;
    apply(v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares a single registered binary-to-Gray conversion datapath between N requesters, with round-robin arbitration.
- Each requester presents a W-bit binary word and raises its request; the winner gets a one-cycle grant.
- The converted Gray word, tagged with the winner's index, is held in a one-entry output register with a valid/ready handshake.
- Sits between the counter/pointer producers and the Gray-encoded consumers (status display, CDC pointer sync).

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, binary/Gray word width (>=2).
- IW, $clog2(N), width of the requester index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; bit i belongs to requester i.
- b  in  N*W  binary words, concatenated; requester i uses b[i*W +: W].
- gnt  out  N  one-hot grant pulse, registered; requester i may change req/b after seeing gnt[i].
- g  out  W  Gray result, g = captured_b ^ (captured_b >> 1).
- g_id  out  IW  index of the requester whose word is in g.
- g_valid  out  1  output register holds an unconsumed result.
- g_ready  in  1  consumer accepts g when g_valid and g_ready are both high.
- conv_cnt  out  16  count of completed transfers (g_valid & g_ready), wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst high at a clock edge): gnt=0, g=0, g_id=0, g_valid=0, conv_cnt=0, state=EMPTY, priority pointer=0 (requester 0 highest). rst overrides every other input.
- Reset mid-operation discards any pending result; requesters that are still requesting are arbitrated afresh from pointer 0.
- State machine, two states:
  - EMPTY: if any req bit is set, pick the winner, capture the result, pulse gnt[winner], go to FULL. If no req, stay EMPTY with gnt=0.
  - FULL, g_ready=1: the transfer completes and conv_cnt increments. If any req is set in the same cycle, capture the next winner, pulse its gnt and stay FULL (back-to-back, 1 result/cycle). Otherwise go to EMPTY and drop g_valid.
  - FULL, g_ready=0: hold g, g_id and g_valid stable; gnt=0; no capture.
- Capture: on the capturing edge, g <= b_w ^ (b_w >> 1), g_id <= w, g_valid <= 1, gnt <= one-hot(w). Latency is 1 cycle from a sampled req to g_valid/gnt. gnt is high for exactly one cycle per capture.
- Arbitration:
  - Search starts at the pointer and proceeds pointer, pointer+1, …, N-1, 0, … ; the first set req bit wins.
  - After a grant to w, the pointer becomes (w+1) mod N, so the most recent winner becomes lowest priority.
  - The pointer changes only on a capture.
- Requester protocol:
  - req is a level and must stay high with b stable until gnt is seen.
  - A requester that keeps req high after its gnt is treated as a new request in the next cycle.
  - req dropping before gnt is legal and withdraws the request.
- Simultaneous events: capture and transfer in the same cycle are handled as in FULL above. conv_cnt counts transfers only, never captures.
- Width rules:
  - Gray MSB equals the binary MSB.
  - No arithmetic on b, so there is no overflow.
  - conv_cnt is modulo 2^16.
- Unused upper index values (N not a power of two) are never generated on g_id.

Test Plan:
- Reset/idle: hold rst 2 cycles, req=0 for 5 cycles -> g_valid=0, gnt=0, g=0000, conv_cnt=0 throughout.
- Single request: req=0001, b0=0101, g_ready=1 -> next cycle gnt=0001, g=0111, g_id=0, g_valid=1; following cycle g_valid=0, conv_cnt=1.
- Round-robin: all req=1111 held continuously, b0..b3=0000,0111,1010,1111, g_ready=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; g = 0000,0100,1111,1000,0000; conv_cnt reaches 4 after the fourth transfer.
- Backpressure: result g=1000 (b=1111) pending, g_ready=0 for 3 cycles with req=0110 -> g, g_id, g_valid stable and gnt=0 for those cycles. g_ready=1 -> transfer, gnt=0010 captured in the same cycle, then 0100 next.
- Reset mid-operation: g_valid=1 with g_ready=0, assert rst one cycle -> g_valid=0, conv_cnt=0, pointer=0. With req=1010 still high, the next grant is 0010.
- Counter wrap: force 65535 transfers then 1 more -> conv_cnt 0xFFFF -> 0x0000. Exhaustive W=4 check: every b 0..15 through requester 2 -> g matches b^(b>>1), g_id=2.
